eth_mac_rx: RTL and testbench
=============================

ETH_MAC_RX -- requirements
Module: eth_mac_rx

Interface
REQ-001 SHALL have parameter MAX_LEN, default 1518, maximum frame length in bytes after the SFD, FCS included.
REQ-002 SHALL have parameter MIN_LEN, default 64, minimum frame length in bytes after the SFD, FCS included.
REQ-003 SHALL have port clk  input  1  the single clock; GMII RX domain and FIFO write side both use it.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port eth_rx_d_in  input  8  GMII receive data.
REQ-006 SHALL have port eth_rx_dv_in  input  1  GMII receive data valid.
REQ-007 SHALL have port eth_rx_err_in  input  1  GMII receive error.
REQ-008 SHALL have port wr_full_in  input  1  eth_fifo full flag.
REQ-009 SHALL have port wr_en_out  output  1  FIFO write strobe, one word per cycle.
REQ-010 SHALL have port wr_d_out  output  36  FIFO word: [31:0] data, [32] last, [34:33] valid bytes minus 1 (last word only, else 0), [35] 0.
REQ-011 SHALL have port wr_chk_out  output  1  commit of the current frame to the FIFO.
REQ-012 SHALL have port wr_clr_out  output  1  discard of uncommitted FIFO words.
REQ-013 SHALL have port frame_ok_out  output  1  one-cycle pulse per committed frame.
REQ-014 SHALL have port frame_err_out  output  1  one-cycle pulse per discarded frame.

Function
REQ-015 SHALL register all eth_rx_* inputs once before use.
REQ-016 SHALL implement states IDLE, PREAMBLE, DATA, DROP.
REQ-017 IDLE: on dv=1 with byte 0x55 -> PREAMBLE; dv=1 with any other byte -> DROP; err ignored.
REQ-018 PREAMBLE: 0x55 stays; 0xD5 -> DATA; other byte -> DROP; dv=0 -> IDLE with no FIFO activity.
REQ-019 DATA: SHALL run CRC-32 (poly 0x04C11DB7, init 0xFFFFFFFF, reflected) over every byte, FCS included; good frame leaves residue 0xC704DD7B.
REQ-020 DATA: SHALL delay bytes through a 4-byte line so FCS bytes are never written; payload bytes are packed little-endian, first byte in [7:0].
REQ-021 SHALL hold each completed word and write it (last=0) only when the next payload byte arrives, so the final word always carries 1-4 bytes.
REQ-022 A word write with wr_full_in=1 SHALL be lost and SHALL mark the frame bad.
REQ-023 eth_rx_err_in=1 with dv=1 in DATA SHALL mark the frame bad.
REQ-024 Byte count > MAX_LEN SHALL assert wr_clr_out and frame_err_out for one cycle and enter DROP.
REQ-025 DROP: no FIFO writes; dv=0 -> IDLE.
REQ-026 End of frame is the first registered dv=0 in DATA; the response SHALL occur exactly 1 cycle later, for one cycle.
REQ-027 Good end of frame requires: CRC residue correct, length >= MIN_LEN, not marked bad, wr_full_in=0. It SHALL assert wr_en_out, wr_chk_out, and frame_ok_out together, with last=1 and correct [34:33].
REQ-028 Any other end of frame SHALL assert wr_clr_out and frame_err_out with wr_en_out=0.
REQ-029 wr_chk_out and wr_clr_out SHALL never be asserted in the same cycle.
REQ-030 After the end-of-frame response the state SHALL be IDLE.

Reset
REQ-031 While rst=1: all outputs 0, state IDLE, CRC 0xFFFFFFFF, counters and packer cleared.
REQ-032 Reset mid-frame SHALL leave the FIFO uncommitted (no wr_chk_out); the FIFO is reset by the same rst.
REQ-033 After rst deasserts, a frame already in progress SHALL be dropped: non-0x55 byte -> DROP.

Verification
REQ-034 7×0x55, 0xD5, 60 payload bytes 0x00..0x3B, valid FCS -> 15 writes; last word 0x3B3A3938 with [32]=1 and [34:33]=3; wr_chk_out and frame_ok_out pulse once.
REQ-035 Same frame with 61 payload bytes -> 16 writes; last word [7:0]=0x3C, [34:33]=0.
REQ-036 Valid frame with one FCS bit flipped -> wr_clr_out and frame_err_out once; wr_chk_out never asserted.
REQ-037 eth_rx_err_in pulsed at payload byte 10, or wr_full_in held for 3 cycles mid-frame -> wr_clr_out and frame_err_out; next valid frame commits normally.
REQ-038 Frame of 63 bytes (runt) -> clear; frame of 1519 bytes -> clear at byte 1519, then DROP until dv=0.
REQ-039 rst asserted at payload byte 20 -> all outputs 0 immediately, no wr_chk_out; next frame after reset commits normally.

Source files
------------

// File: rtl/eth_mac_rx.sv
// eth_mac_rx: GMII receive MAC front end.
// Strips preamble/SFD, checks the CRC-32 FCS, and packs payload bytes
// little-endian into 36-bit FIFO words. A frame is committed (wr_chk_out)
// when it ends good, or discarded (wr_clr_out) when anything goes wrong.
module eth_mac_rx #(
    parameter int unsigned MAX_LEN = 1518,
    parameter int unsigned MIN_LEN = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  eth_rx_d_in,
    input  logic        eth_rx_dv_in,
    input  logic        eth_rx_err_in,
    input  logic        wr_full_in,
    output logic        wr_en_out,
    output logic [35:0] wr_d_out,
    output logic        wr_chk_out,
    output logic        wr_clr_out,
    output logic        frame_ok_out,
    output logic        frame_err_out
);

    typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    // 0xC704DD7B seen through the LSB-first (reflected) shift register.
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
    localparam logic [15:0] MAX_L       = 16'(MAX_LEN);
    localparam logic [15:0] MIN_L       = 16'(MIN_LEN);

    // One byte through the reflected CRC-32 (poly 0x04C11DB7 -> 0xEDB88320).
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++)
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        return r;
    endfunction

    state_t      state, state_nxt;
    logic [7:0]  rx_d;
    logic        rx_dv, rx_err;
    logic [31:0] crc;
    logic [31:0] dly;        // FCS holdback line, oldest byte in [7:0]
    logic [2:0]  dly_cnt;    // bytes held in dly, 0..4
    logic [31:0] word;       // payload word being packed
    logic [2:0]  word_cnt;   // bytes in word, 0..4
    logic [15:0] byte_cnt;   // bytes after SFD, FCS included
    logic        bad;

    logic        frame_start, take_byte, eof, too_long, frame_good;
    logic [2:0]  last_cnt;

    // Input capture: every GMII input is registered once before use.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_d   <= '0;
            rx_dv  <= 1'b0;
            rx_err <= 1'b0;
        end else begin
            // NOTE: sequential state uses <= so every flop samples pre-edge values.
            rx_d   <= eth_rx_d_in;
            rx_dv  <= eth_rx_dv_in;
            rx_err <= eth_rx_err_in;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and per-cycle frame events.
    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned (no latches).
        state_nxt   = state;
        frame_start = 1'b0;
        take_byte   = 1'b0;
        eof         = 1'b0;
        too_long    = (byte_cnt >= MAX_L);
        last_cnt    = word_cnt - 3'd1;
        frame_good  = (crc == CRC_RESIDUE) && (byte_cnt >= MIN_L) && !bad &&
                      !wr_full_in && !(wr_en_out && wr_full_in);
        case (state)
            IDLE: begin
                if (rx_dv) state_nxt = (rx_d == 8'h55) ? PREAMBLE : DROP;
            end
            PREAMBLE: begin
                if (!rx_dv)               state_nxt = IDLE;
                else if (rx_d == 8'hD5) begin
                    state_nxt   = DATA;
                    frame_start = 1'b1;
                end
                else if (rx_d != 8'h55)   state_nxt = DROP;
            end
            DATA: begin
                if (!rx_dv) begin
                    eof       = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    take_byte = 1'b1;
                    if (too_long) state_nxt = DROP;
                end
            end
            DROP: begin
                if (!rx_dv) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: CRC, FCS holdback, word packing, and registered FIFO strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc           <= CRC_INIT;
            dly           <= '0;
            dly_cnt       <= '0;
            word          <= '0;
            word_cnt      <= '0;
            byte_cnt      <= '0;
            bad           <= 1'b0;
            wr_en_out     <= 1'b0;
            wr_d_out      <= '0;
            wr_chk_out    <= 1'b0;
            wr_clr_out    <= 1'b0;
            frame_ok_out  <= 1'b0;
            frame_err_out <= 1'b0;
        end else begin
            wr_en_out     <= 1'b0;
            wr_d_out      <= '0;
            wr_chk_out    <= 1'b0;
            wr_clr_out    <= 1'b0;
            frame_ok_out  <= 1'b0;
            frame_err_out <= 1'b0;
            // A word presented while the FIFO is full is lost.
            if (wr_en_out && wr_full_in) bad <= 1'b1;

            if (frame_start) begin
                crc      <= CRC_INIT;
                dly_cnt  <= '0;
                word_cnt <= '0;
                byte_cnt <= '0;
                bad      <= 1'b0;
            end else if (take_byte) begin
                if (too_long) begin
                    wr_clr_out    <= 1'b1;
                    frame_err_out <= 1'b1;
                end else begin
                    crc      <= crc_byte(crc, rx_d);
                    byte_cnt <= byte_cnt + 16'd1;
                    if (rx_err) bad <= 1'b1;
                    dly      <= {rx_d, dly[31:8]};
                    if (dly_cnt == 3'd4) begin
                        // Oldest byte leaves the holdback line: it is payload.
                        if (word_cnt == 3'd4) begin
                            wr_en_out <= 1'b1;
                            wr_d_out  <= {4'b0000, word};
                            word      <= {24'h0, dly[7:0]};
                            word_cnt  <= 3'd1;
                        end else begin
                            word[{word_cnt[1:0], 3'b000} +: 8] <= dly[7:0];
                            word_cnt <= word_cnt + 3'd1;
                        end
                    end else begin
                        dly_cnt <= dly_cnt + 3'd1;
                    end
                end
            end else if (eof) begin
                if (frame_good) begin
                    wr_en_out    <= 1'b1;
                    wr_d_out     <= {1'b0, last_cnt[1:0], 1'b1, word};
                    wr_chk_out   <= 1'b1;
                    frame_ok_out <= 1'b1;
                end else begin
                    wr_clr_out    <= 1'b1;
                    frame_err_out <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_eth_mac_rx.sv
// Self-checking bench for eth_mac_rx: directed frame sequence with random
// payloads, checked against a byte-list model of the expected FIFO traffic.
module tb_eth_mac_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  eth_rx_d_in;
    logic        eth_rx_dv_in, eth_rx_err_in, wr_full_in;
    logic        wr_en_out, wr_chk_out, wr_clr_out, frame_ok_out, frame_err_out;
    logic [35:0] wr_d_out;

    eth_mac_rx #(.MAX_LEN(1518), .MIN_LEN(64)) dut (
        .clk(clk), .rst(rst),
        .eth_rx_d_in(eth_rx_d_in), .eth_rx_dv_in(eth_rx_dv_in),
        .eth_rx_err_in(eth_rx_err_in), .wr_full_in(wr_full_in),
        .wr_en_out(wr_en_out), .wr_d_out(wr_d_out), .wr_chk_out(wr_chk_out),
        .wr_clr_out(wr_clr_out), .frame_ok_out(frame_ok_out),
        .frame_err_out(frame_err_out)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;

    // Output monitor: logs FIFO writes and counts pulses, sampled on negedge.
    logic [35:0] wr_log [0:4095];
    int wr_total = 0, chk_total = 0, clr_total = 0, ok_total = 0, err_total = 0;
    int both_total = 0, en_clr_total = 0, clr_mark = 0;
    always @(negedge clk) begin
        if (!rst) begin
            if (wr_en_out) begin
                wr_log[wr_total % 4096] = wr_d_out;
                wr_total++;
            end
            if (wr_chk_out) chk_total++;
            if (wr_clr_out) begin
                clr_total++;
                clr_mark = wr_total;
            end
            if (frame_ok_out)  ok_total++;
            if (frame_err_out) err_total++;
            if (wr_chk_out && wr_clr_out) both_total++;
            if (wr_en_out && wr_clr_out) en_clr_total++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [7:0] pl[$];
    int b_wr, b_chk, b_clr, b_ok, b_err;

    task automatic snap();
        b_wr = wr_total; b_chk = chk_total; b_clr = clr_total;
        b_ok = ok_total; b_err = err_total;
    endtask

    task automatic fill_inc(input int n);
        pl = {};
        for (int k = 0; k < n; k++) pl.push_back(8'(k));
    endtask

    task automatic fill_rand(input int n);
        pl = {};
        for (int k = 0; k < n; k++) pl.push_back(8'($urandom_range(0, 255)));
    endtask

    // FCS of the current payload: complement of the LSB-first CRC-32.
    function automatic logic [31:0] fcs_of();
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        foreach (pl[k])
            for (int b = 0; b < 8; b++)
                c = (c[0] ^ pl[k][b]) ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        return ~c;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            eth_rx_dv_in = 1'b0; eth_rx_err_in = 1'b0; eth_rx_d_in = 8'h00;
        end
    endtask

    task automatic drive_byte(input logic [7:0] b);
        @(negedge clk);
        eth_rx_d_in = b; eth_rx_dv_in = 1'b1; eth_rx_err_in = 1'b0;
    endtask

    // Sends 7x55, D5, payload, FCS. Options: flip an FCS bit, pulse err at a
    // payload index, hold full for 3 cycles over a write, reset mid-frame.
    task automatic send_frame(input int flip_bit, input int err_at,
                              input bit full_on, input int rst_at);
        logic [7:0]  tx[$];
        logic [7:0]  tmp;
        logic [31:0] f;
        int          full_left;
        bit          did_rst;
        tx = {};
        repeat (7) tx.push_back(8'h55);
        tx.push_back(8'hD5);
        foreach (pl[k]) tx.push_back(pl[k]);
        f = fcs_of();
        for (int k = 0; k < 4; k++) tx.push_back(f[8*k +: 8]);
        if (flip_bit >= 0) begin
            tmp = tx[8 + pl.size() + flip_bit / 8];
            tmp[flip_bit % 8] = ~tmp[flip_bit % 8];
            tx[8 + pl.size() + flip_bit / 8] = tmp;
        end
        full_left = 0;
        did_rst = 1'b0;
        for (int i = 0; i < tx.size(); i++) begin
            @(negedge clk);
            if (full_left > 0) begin
                full_left--;
                if (full_left == 0) wr_full_in = 1'b0;
            end else if (full_on && i >= 28 && wr_en_out) begin
                wr_full_in = 1'b1;
                full_left = 3;
                full_on = 1'b0;
            end
            if (rst_at >= 0 && !did_rst && i >= 8 + rst_at && wr_en_out) begin
                rst = 1'b1;
                #1;
                check("rst_clears_outputs",
                      64'({wr_en_out, wr_d_out, wr_chk_out, wr_clr_out, frame_ok_out, frame_err_out}),
                      64'd0);
                did_rst = 1'b1;
                repeat (3) @(negedge clk);
                rst = 1'b0;
            end
            if (did_rst && i >= 8 + pl.size()) break;
            eth_rx_d_in   = tx[i];
            eth_rx_dv_in  = 1'b1;
            eth_rx_err_in = (i - 8 == err_at);
        end
        wr_full_in = 1'b0;
        idle(8);
    endtask

    // Compares the traffic since snap() with what the frame should produce.
    task automatic check_result(input string tag, input bit exp_good, input bit exp_clr);
        int n, nbad;
        logic [35:0] exp_w;
        check({tag, "_chk"}, 64'(chk_total - b_chk), exp_good ? 64'd1 : 64'd0);
        check({tag, "_ok"},  64'(ok_total - b_ok),   exp_good ? 64'd1 : 64'd0);
        check({tag, "_clr"}, 64'(clr_total - b_clr), exp_clr ? 64'd1 : 64'd0);
        check({tag, "_err"}, 64'(err_total - b_err), exp_clr ? 64'd1 : 64'd0);
        if (exp_good) begin
            n = (pl.size() + 3) / 4;
            check({tag, "_writes"}, 64'(wr_total - b_wr), 64'(n));
            nbad = 0;
            for (int w = 0; w < n; w++) begin
                exp_w = '0;
                for (int k = 0; k < 4; k++)
                    if (4*w + k < pl.size()) exp_w[8*k +: 8] = pl[4*w + k];
                if (w == n - 1) begin
                    exp_w[32] = 1'b1;
                    exp_w[34:33] = 2'(pl.size() - 4*w - 1);
                end
                if (wr_log[(b_wr + w) % 4096] !== exp_w) nbad++;
            end
            check({tag, "_bad_words"}, 64'(nbad), 64'd0);
        end else if (!exp_clr) begin
            check({tag, "_writes"}, 64'(wr_total - b_wr), 64'd0);
        end
    endtask

    initial begin
        rst = 1'b1;
        eth_rx_d_in = 8'h00; eth_rx_dv_in = 1'b0; eth_rx_err_in = 1'b0; wr_full_in = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              64'({wr_en_out, wr_d_out, wr_chk_out, wr_clr_out, frame_ok_out, frame_err_out}),
              64'd0);
        rst = 1'b0;
        idle(3);

        // 64-byte minimum frame, incrementing payload.
        fill_inc(60); snap(); send_frame(-1, -1, 1'b0, -1);
        check_result("min64", 1'b1, 1'b0);
        check("min64_last_word", 64'(wr_log[(wr_total - 1) % 4096]), 64'h7_3B3A_3938);

        // One byte more: last word carries a single byte.
        fill_inc(61); snap(); send_frame(-1, -1, 1'b0, -1);
        check_result("len65", 1'b1, 1'b0);
        check("len65_last_word", 64'(wr_log[(wr_total - 1) % 4096]), 64'h1_0000_003C);

        // Random good frames of assorted lengths.
        for (int r = 0; r < 3; r++) begin
            fill_rand($urandom_range(60, 200)); snap(); send_frame(-1, -1, 1'b0, -1);
            check_result($sformatf("rand%0d", r), 1'b1, 1'b0);
        end

        // Corrupted FCS.
        fill_rand(80); snap(); send_frame($urandom_range(0, 31), -1, 1'b0, -1);
        check_result("bad_fcs", 1'b0, 1'b1);

        // Receive error at payload byte 10, then a good frame.
        fill_rand(70); snap(); send_frame(-1, 10, 1'b0, -1);
        check_result("rx_err", 1'b0, 1'b1);
        fill_rand(66); snap(); send_frame(-1, -1, 1'b0, -1);
        check_result("after_err", 1'b1, 1'b0);

        // FIFO full over a write, then a good frame.
        fill_rand(90); snap(); send_frame(-1, -1, 1'b1, -1);
        check_result("fifo_full", 1'b0, 1'b1);
        fill_rand(64); snap(); send_frame(-1, -1, 1'b0, -1);
        check_result("after_full", 1'b1, 1'b0);

        // Runt: 63 bytes after SFD.
        fill_rand(59); snap(); send_frame(-1, -1, 1'b0, -1);
        check_result("runt63", 1'b0, 1'b1);

        // Maximum length: 1518 bytes is accepted.
        fill_rand(1514); snap(); send_frame(-1, -1, 1'b0, -1);
        check_result("max1518", 1'b1, 1'b0);

        // Oversize: 1525 bytes, cleared at byte 1519 and nothing written afterwards.
        fill_rand(1521); snap(); send_frame(-1, -1, 1'b0, -1);
        check_result("over", 1'b0, 1'b1);
        check("over_writes_after_clr", 64'(wr_total - clr_mark), 64'd0);

        // Frame not starting with 0x55 is ignored entirely.
        fill_inc(60); snap();
        drive_byte(8'hAA);
        repeat (7) drive_byte(8'h55);
        drive_byte(8'hD5);
        foreach (pl[k]) drive_byte(pl[k]);
        idle(8);
        check_result("idle_drop", 1'b0, 1'b0);

        // Preamble abandoned before SFD.
        snap();
        repeat (3) drive_byte(8'h55);
        idle(8);
        check_result("pre_abort", 1'b0, 1'b0);

        // Reset mid-frame: never committed, remainder dropped, next frame good.
        fill_inc(60); snap(); send_frame(-1, -1, 1'b0, 20);
        check("rst_no_chk", 64'(chk_total - b_chk), 64'd0);
        check("rst_no_ok",  64'(ok_total - b_ok),   64'd0);
        check("rst_no_clr", 64'(clr_total - b_clr), 64'd0);
        fill_rand(100); snap(); send_frame(-1, -1, 1'b0, -1);
        check_result("after_rst", 1'b1, 1'b0);

        check("chk_and_clr_together", 64'(both_total), 64'd0);
        check("wr_en_with_clr", 64'(en_clr_total), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #2_000_000;
        $display("FAIL timeout: sequence did not complete");
        mismatched++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $fatal(1, "timeout");
    end

endmodule
